// File: rtl/bmem_arb_pkg.sv
// bmem_arb_pkg
//   Shared definitions for the bmem write-port arbiter: bus widths, the
//   arbiter FSM state type and the default response-watchdog limit.
//   BMEM_TIMEOUT_CYCLES matches the HID report timer's 200000-cycle period,
//   so a stuck write is abandoned within one report interval.
package bmem_arb_pkg;

    localparam int unsigned BMEM_DATA_W = 64;
    localparam int unsigned BMEM_ADDR_W = 32;

    localparam logic [17:0] BMEM_TIMEOUT_CYCLES = 18'd200000;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick. The search starts one position above
//   ptr and wraps modulo NUM_REQ, so the most recent winner has the lowest
//   priority. The pointer register itself lives in the parent.
// Ports:
//   req      in   NUM_REQ  request levels
//   ptr      in   IDX_W    index of the previous winner
//   grant    out  NUM_REQ  one-hot winner (all zero when no request)
//   idx      out  IDX_W    winner index
//   any_req  out  1        at least one request is set
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_req
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/bmem_wr_arbiter.sv
// bmem_wr_arbiter
//   Shares the single bmem write port between NUM_REQ report producers.
//   In IDLE a round-robin winner is chosen, its data/address captured and
//   gnt pulsed; in BUSY bmem_wr_en is held until bmem_resp, after which
//   done is pulsed for the winner.
//   Optional macro BMEM_ARB_TIMEOUT_EN adds a response watchdog that aborts
//   the write after TIMEOUT_CYCLES BUSY cycles, pulsing err and setting the
//   sticky timeout_seen flag.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req             per-requester request level
//   req_data        64 bits per requester, requester i at [64*i +: 64]
//   req_addr        32 bits per requester, requester i at [32*i +: 32]
//   gnt/done/err    one-cycle one-hot pulses per requester
//   timeout_seen    sticky watchdog flag
//   bmem_wr_en      write request level to bmem
//   bmem_wr_data    captured write data
//   bmem_wr_addr    captured write address
//   bmem_resp       write-complete strobe from bmem
module bmem_wr_arbiter
    import bmem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter logic [17:0] TIMEOUT_CYCLES = BMEM_TIMEOUT_CYCLES
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*BMEM_DATA_W-1:0] req_data,
    input  logic [NUM_REQ*BMEM_ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             done,
    output logic [NUM_REQ-1:0]             err,
    output logic                           timeout_seen,
    output logic                           bmem_wr_en,
    output logic [BMEM_DATA_W-1:0]         bmem_wr_data,
    output logic [BMEM_ADDR_W-1:0]         bmem_wr_addr,
    input  logic                           bmem_resp
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t             state;
    logic [IDX_W-1:0]       ptr;
    logic [NUM_REQ-1:0]     owner;
    logic [NUM_REQ-1:0]     win_oh;
    logic [IDX_W-1:0]       win_idx;
    logic                   any_req;
    logic [BMEM_DATA_W-1:0] win_data;
    logic [BMEM_ADDR_W-1:0] win_addr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (req),
        .ptr     (ptr),
        .grant   (win_oh),
        .idx     (win_idx),
        .any_req (any_req)
    );

    // One-hot mux of the winner's payload.
    always_comb begin
        win_data = '0;
        win_addr = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_data = req_data[i*BMEM_DATA_W +: BMEM_DATA_W];
                win_addr = req_addr[i*BMEM_ADDR_W +: BMEM_ADDR_W];
            end
        end
    end

`ifdef BMEM_ARB_TIMEOUT_EN
    logic [17:0] wd_cnt;
`else
    // The watchdog limit is kept on the interface even when compiled out.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign err          = '0;
    assign timeout_seen = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= IDX_W'(NUM_REQ - 1);
            owner        <= '0;
            gnt          <= '0;
            done         <= '0;
            bmem_wr_en   <= 1'b0;
            bmem_wr_data <= '0;
            bmem_wr_addr <= '0;
`ifdef BMEM_ARB_TIMEOUT_EN
            err          <= '0;
            timeout_seen <= 1'b0;
            wd_cnt       <= '0;
`endif
        end else begin
            gnt  <= '0;
            done <= '0;
`ifdef BMEM_ARB_TIMEOUT_EN
            err  <= '0;
`endif
            case (state)
                IDLE: begin
                    if (any_req) begin
                        ptr          <= win_idx;
                        owner        <= win_oh;
                        gnt          <= win_oh;
                        bmem_wr_data <= win_data;
                        bmem_wr_addr <= win_addr;
                        bmem_wr_en   <= 1'b1;
                        state        <= BUSY;
`ifdef BMEM_ARB_TIMEOUT_EN
                        wd_cnt       <= '0;
`endif
                    end
                end
                BUSY: begin
                    // A response in the expiry cycle takes precedence.
                    if (bmem_resp) begin
                        done       <= owner;
                        bmem_wr_en <= 1'b0;
                        state      <= IDLE;
                    end
`ifdef BMEM_ARB_TIMEOUT_EN
                    else if (wd_cnt == TIMEOUT_CYCLES - 18'd1) begin
                        err          <= owner;
                        timeout_seen <= 1'b1;
                        bmem_wr_en   <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 18'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bmem_wr_arbiter.md
# bmem_wr_arbiter

Shares the single AXI-side bmem write port (bmem_wr_en / bmem_wr_data / bmem_wr_addr / bmem_resp) between several report producers, such as the HID report timer and a descriptor/log writer. It arbitrates round-robin, captures the winner's 64-bit word and 32-bit address, and holds the write until the memory side responds. It then reports completion to the winning requester. An optional watchdog aborts writes whose response never arrives.

## Interface
- NUM_REQ, 2: number of requesters (2..8).
- TIMEOUT_CYCLES, 18'd200000: response watchdog limit in clk cycles; used only with the macro in Configuration.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester request level.
- req_data  in  NUM_REQ*64  write data; requester i uses bits [64*i+63:64*i].
- req_addr  in  NUM_REQ*32  write address; requester i uses bits [32*i+31:32*i].
- gnt  out  NUM_REQ  one-cycle pulse: request i accepted and its data/addr captured.
- done  out  NUM_REQ  one-cycle pulse: write for i completed (bmem_resp seen).
- err  out  NUM_REQ  one-cycle pulse: write for i aborted by the watchdog.
- timeout_seen  out  1  sticky watchdog flag; cleared only by rst.
- bmem_wr_en  out  1  write request level to bmem.
- bmem_wr_data  out  64  captured write data.
- bmem_wr_addr  out  32  captured write address.
- bmem_resp  in  1  write-complete strobe from bmem.

## Operation
- FSM states: IDLE and BUSY. Reset state is IDLE.
- Reset values: all outputs 0; round-robin pointer = NUM_REQ-1, so requester 0 has first priority; watchdog counter 0.
- IDLE, with any req bit high:
  - Pick the winner: the first requester with req set, searching from pointer+1 upward and wrapping modulo NUM_REQ.
  - Register the winner's data/addr into bmem_wr_data/bmem_wr_addr.
  - Set pointer to the winner, register gnt[winner] for one cycle, go to BUSY.
- BUSY:
  - bmem_wr_en = 1; bmem_wr_data/bmem_wr_addr stay stable.
  - req is ignored.
  - On bmem_resp = 1: go to IDLE and pulse done[winner] in the next cycle.
- bmem_resp in IDLE is ignored (spurious).
- Requester rules:
  - Hold req, data and addr stable until gnt.
  - Drop req in the gnt cycle, or keep it high to queue a new request.
  - A req still high after gnt is treated as a fresh request with the then-current data.
- Fairness: a continuously requesting i waits at most NUM_REQ-1 other writes.
- Reset mid-write: bmem_wr_en drops the cycle after rst. No done or err is issued, and a later bmem_resp is ignored.

## Timing
- req rises in cycle t, state IDLE, arbiter wins → gnt, bmem_wr_en and bmem_wr_data/bmem_wr_addr all valid at t+1.
- bmem_resp sampled at cycle r → bmem_wr_en = 0 and done pulse at r+1.
- Minimum write with bmem_resp in the first BUSY cycle: gnt and bmem_wr_en at t+1, done at t+2.
- Back-to-back: the state is IDLE at r+1. A waiting request is arbitrated there, with the next gnt/bmem_wr_en at r+2. Peak rate is one write per 2 cycles.
- gnt, done and err are single-cycle pulses; at most one bit of each is set in any cycle.

## Configuration
- BMEM_ARB_TIMEOUT_EN defined:
  - An 18-bit counter clears on entry to BUSY and increments each BUSY cycle without bmem_resp.
  - When it reaches TIMEOUT_CYCLES-1 with no bmem_resp: go to IDLE, drop bmem_wr_en next cycle, pulse err[winner], set timeout_seen.
  - bmem_resp in the same cycle as expiry wins: done is issued, err is not.
- Undefined:
  - BUSY waits indefinitely for bmem_resp.
  - err and timeout_seen are tied to 0; no counter is present.

## Structure
- Package bmem_arb_pkg holds:
  - BMEM_DATA_W = 64, BMEM_ADDR_W = 32;
  - the state enum (IDLE, BUSY);
  - the default TIMEOUT_CYCLES constant, shared with the HID report timer's 200000-cycle period.
- Sub-module rr_arbiter: combinational round-robin pick. Inputs are req and pointer; outputs are the one-hot winner, the winner index, and any_req. The parent holds the pointer register.

## Test plan
- Single request: req[0] with data 64'hDEAD_BEEF_0123_4567 and addr 32'h0000_1000; bmem_resp 3 cycles into BUSY → gnt[0] at t+1, bmem_wr_en high for exactly 3 cycles, done[0] one cycle after bmem_resp, bus values match.
- Contention: req = 2'b11 held continuously, bmem_resp immediate → grants alternate 0, 1, 0, 1, with a gnt every 2 cycles.
- Back-to-back from one requester: req[1] held high with incrementing data → each gnt carries the data present in its arbitration cycle; no write is lost or duplicated.
- Spurious and late responses: bmem_resp pulsed in IDLE → no done, no state change. rst asserted while BUSY, then bmem_resp → bmem_wr_en is 0 after the reset, no done.
- With BMEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, no bmem_resp → err[0] and timeout_seen set after 16 BUSY cycles. Repeat with bmem_resp in the expiry cycle → done[0], no err.
